// File: rtl/scandoubler_vid_sched.sv
// Video-side burst scheduler for the scandoubler SDRAM controller: input FIFO feeding
// 8-word write bursts, 8-word read prefetch into the output FIFO, triple-buffered frames.
module scandoubler_vid_sched #(
  parameter int LINE_WORDS = 640,
  parameter int BURST      = 8
) (
  input  logic        clk_96,
  input  logic        reset,
  input  logic        in_frame_start,
  input  logic        in_line_start,
  input  logic        in_valid,
  input  logic [15:0] in_d,
  output logic        vidin_req,
  output logic [1:0]  vidin_frame,
  output logic [10:0] vidin_row,
  output logic [10:0] vidin_col,
  output logic [15:0] vidin_d,
  input  logic        vidin_ack,
  input  logic        out_frame_start,
  input  logic        out_line_start,
  input  logic [10:0] out_row,
  input  logic        out_rd,
  output logic [15:0] out_q,
  output logic        out_empty,
  output logic        vidout_req,
  output logic [1:0]  vidout_frame,
  output logic [10:0] vidout_row,
  output logic [10:0] vidout_col,
  input  logic [15:0] vidout_q,
  input  logic        vidout_ack,
  output logic        in_overflow,
  output logic        out_underflow
);

  localparam int IN_DEPTH  = 16;
  localparam int OUT_DEPTH = 32;
  localparam int QUIET     = 24;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_BURST} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_BURST, R_FLUSH} rstate_t;

  // Lowest-numbered frame that is neither being written nor being displayed.
  function automatic logic [1:0] free_frame(input logic [1:0] a, input logic [1:0] b);
    if (a != 2'd0 && b != 2'd0)      return 2'd0;
    else if (a != 2'd1 && b != 2'd1) return 2'd1;
    else                             return 2'd2;
  endfunction

  wstate_t     wstate, wstate_nxt;
  rstate_t     rstate, rstate_nxt;

  logic [15:0] in_mem [IN_DEPTH];
  logic [3:0]  in_rptr, in_wptr;
  logic [4:0]  in_cnt;
  logic        in_push, in_pop;

  logic [15:0] out_mem [OUT_DEPTH];
  logic [4:0]  out_rptr, out_wptr;
  logic [5:0]  out_cnt;
  logic        out_push, out_pop;

  logic        line_pend, frame_pend, line_apply, frame_apply;
  logic        row_zero, wr_done;
  logic [2:0]  wcnt;
  logic [1:0]  last_done;

  logic [2:0]  rcnt;
  logic [4:0]  qcnt;
  logic [10:0] pend_row;
  logic        rd_accept, rd_done, flush_done, rd_room;
  logic [3:0]  rd_outstanding;

  // Line/frame starts only take effect between bursts so the burst address never moves.
  assign line_apply  = (in_line_start  | line_pend)  && (wstate != W_BURST);
  assign frame_apply = (in_frame_start | frame_pend) && (wstate != W_BURST);

  assign in_push = in_valid && (line_apply || in_cnt != 5'(IN_DEPTH));
  assign in_pop  = vidin_ack && (in_cnt != 5'd0) && !line_apply;
  assign vidin_d = (in_cnt != 5'd0) ? in_mem[in_rptr] : 16'd0;

  always_comb begin
    wstate_nxt = wstate;
    wr_done    = 1'b0;
    case (wstate)
      W_IDLE:  if (!line_apply && !frame_apply && in_cnt >= 5'(BURST) &&
                   vidin_col < 11'(LINE_WORDS))
                 wstate_nxt = W_REQ;
      W_REQ:   if (line_apply || frame_apply) wstate_nxt = W_IDLE;
               else if (vidin_ack)            wstate_nxt = W_BURST;
      W_BURST: if (vidin_ack && wcnt == 3'(BURST - 1)) begin
                 wstate_nxt = W_IDLE;
                 wr_done    = 1'b1;
               end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_96) begin
    if (reset) begin
      wstate      <= W_IDLE;
      vidin_req   <= 1'b0;
      wcnt        <= 3'd0;
      line_pend   <= 1'b0;
      frame_pend  <= 1'b0;
      row_zero    <= 1'b1;
      vidin_row   <= 11'd0;
      vidin_col   <= 11'd0;
      vidin_frame <= 2'd0;
      last_done   <= 2'd2;
      in_overflow <= 1'b0;
      in_rptr     <= 4'd0;
      in_wptr     <= 4'd0;
      in_cnt      <= 5'd0;
    end else begin
      wstate     <= wstate_nxt;
      vidin_req  <= (wstate_nxt == W_REQ) || (wstate_nxt == W_BURST);
      line_pend  <= line_apply  ? 1'b0 : (line_pend  | in_line_start);
      frame_pend <= frame_apply ? 1'b0 : (frame_pend | in_frame_start);
      if (wstate != W_IDLE && vidin_ack && !line_apply && !frame_apply)
        wcnt <= wcnt + 3'd1;
      if (frame_apply) begin
        last_done   <= vidin_frame;
        vidin_frame <= free_frame(vidin_frame, vidout_frame);
      end
      if (line_apply) begin
        vidin_row <= (row_zero || frame_apply) ? 11'd0 : vidin_row + 11'd1;
        vidin_col <= 11'd0;
        row_zero  <= 1'b0;
      end else begin
        if (frame_apply) row_zero <= 1'b1;
        if (wr_done)     vidin_col <= vidin_col + 11'(BURST);
      end
      if ((in_valid && !line_apply && in_cnt == 5'(IN_DEPTH)) ||
          (vidin_ack && in_cnt == 5'd0))
        in_overflow <= 1'b1;
      if (line_apply) begin
        in_rptr <= 4'd0;
        in_wptr <= in_push ? 4'd1 : 4'd0;
        in_cnt  <= in_push ? 5'd1 : 5'd0;
      end else begin
        if (in_push) in_wptr <= in_wptr + 4'd1;
        if (in_pop)  in_rptr <= in_rptr + 4'd1;
        in_cnt <= in_cnt + 5'(in_push) - 5'(in_pop);
      end
    end
  end

  always_ff @(posedge clk_96) begin
    if (in_push) in_mem[line_apply ? 4'd0 : in_wptr] <= in_d;
  end

  // Read side: prefetch only while the burst in flight plus the FIFO still fits a burst.
  assign rd_accept      = ((rstate == R_REQ) || (rstate == R_BURST)) && !out_line_start;
  assign rd_outstanding = ((rstate == R_REQ) || (rstate == R_BURST)) ?
                          4'(BURST) - {1'b0, rcnt} : 4'd0;
  assign rd_room        = (7'(OUT_DEPTH) - {1'b0, out_cnt} - {3'b0, rd_outstanding})
                          >= 7'(BURST);

  assign out_pop   = out_rd && (out_cnt != 6'd0) && !flush_done;
  assign out_push  = rd_accept && vidout_ack && (out_cnt != 6'(OUT_DEPTH) || out_pop);
  assign out_empty = (out_cnt == 6'd0);
  assign out_q     = out_empty ? 16'd0 : out_mem[out_rptr];

  always_comb begin
    rstate_nxt = rstate;
    rd_done    = 1'b0;
    flush_done = 1'b0;
    if (out_line_start) begin
      rstate_nxt = R_FLUSH;
    end else begin
      case (rstate)
        R_IDLE:  if (vidout_col < 11'(LINE_WORDS) && rd_room) rstate_nxt = R_REQ;
        R_REQ:   if (vidout_ack) rstate_nxt = R_BURST;
        R_BURST: if (vidout_ack && rcnt == 3'(BURST - 1)) begin
                   rstate_nxt = R_IDLE;
                   rd_done    = 1'b1;
                 end
        R_FLUSH: if (!vidout_ack && qcnt == 5'(QUIET - 1)) begin
                   rstate_nxt = R_IDLE;
                   flush_done = 1'b1;
                 end
        default: rstate_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_96) begin
    if (reset) begin
      rstate        <= R_IDLE;
      vidout_req    <= 1'b0;
      rcnt          <= 3'd0;
      qcnt          <= 5'd0;
      pend_row      <= 11'd0;
      vidout_row    <= 11'd0;
      vidout_col    <= 11'd0;
      vidout_frame  <= 2'd2;
      out_underflow <= 1'b0;
      out_rptr      <= 5'd0;
      out_wptr      <= 5'd0;
      out_cnt       <= 6'd0;
    end else begin
      rstate     <= rstate_nxt;
      vidout_req <= (rstate_nxt == R_REQ) || (rstate_nxt == R_BURST);
      if (out_line_start)              rcnt <= 3'd0;
      else if (rd_accept && vidout_ack) rcnt <= rcnt + 3'd1;
      if (out_line_start || vidout_ack) qcnt <= 5'd0;
      else if (rstate == R_FLUSH)       qcnt <= qcnt + 5'd1;
      if (out_line_start) pend_row <= out_row;
      if (flush_done) begin
        vidout_row <= pend_row;
        vidout_col <= 11'd0;
      end else if (rd_done) begin
        vidout_col <= vidout_col + 11'(BURST);
      end
      if (out_frame_start) vidout_frame <= last_done;
      if (out_rd && out_cnt == 6'd0) out_underflow <= 1'b1;
      if (flush_done) begin
        out_rptr <= 5'd0;
        out_wptr <= 5'd0;
        out_cnt  <= 6'd0;
      end else begin
        if (out_push) out_wptr <= out_wptr + 5'd1;
        if (out_pop)  out_rptr <= out_rptr + 5'd1;
        out_cnt <= out_cnt + 6'(out_push) - 6'(out_pop);
      end
    end
  end

  always_ff @(posedge clk_96) begin
    if (out_push) out_mem[out_wptr] <= vidout_q;
  end

endmodule

// File: tb/tb_scandoubler_vid_sched.sv
// Directed bench for scandoubler_vid_sched (LINE_WORDS=64): write bursts, line/frame
// sequencing, overflow, triple buffer, read prefetch throttling and flush.
module tb_scandoubler_vid_sched;

  logic        clk_96 = 1'b0;
  logic        reset = 1'b1;
  logic        in_frame_start = 1'b0, in_line_start = 1'b0, in_valid = 1'b0;
  logic [15:0] in_d = 16'd0;
  logic        vidin_req, vidin_ack = 1'b0;
  logic [1:0]  vidin_frame, vidout_frame;
  logic [10:0] vidin_row, vidin_col, vidout_row, vidout_col;
  logic [15:0] vidin_d, out_q;
  logic        out_frame_start = 1'b0, out_line_start = 1'b0, out_rd = 1'b0;
  logic [10:0] out_row = 11'd0;
  logic        out_empty, vidout_req, vidout_ack = 1'b0;
  logic [15:0] vidout_q = 16'd0;
  logic        in_overflow, out_underflow;

  int n_cmp = 0;
  int n_err = 0;

  scandoubler_vid_sched #(.LINE_WORDS(64)) dut (
    .clk_96(clk_96), .reset(reset),
    .in_frame_start(in_frame_start), .in_line_start(in_line_start),
    .in_valid(in_valid), .in_d(in_d),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .out_frame_start(out_frame_start), .out_line_start(out_line_start),
    .out_row(out_row), .out_rd(out_rd), .out_q(out_q), .out_empty(out_empty),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_q(vidout_q), .vidout_ack(vidout_ack),
    .in_overflow(in_overflow), .out_underflow(out_underflow)
  );

  always #5 clk_96 = ~clk_96;

  task automatic tick();
    @(posedge clk_96);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_in_req(input string tag);
    int n = 0;
    while (vidin_req !== 1'b1 && n < 20) begin tick(); n++; end
    chk(tag, 32'(vidin_req), 32'd1);
  endtask

  task automatic wait_out_req(input string tag);
    int n = 0;
    while (vidout_req !== 1'b1 && n < 40) begin tick(); n++; end
    chk(tag, 32'(vidout_req), 32'd1);
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1; in_d = d; tick(); in_valid = 1'b0;
  endtask

  task automatic in_ack_word(input string tag, input logic [31:0] exp);
    chk(tag, 32'(vidin_d), exp);
    vidin_ack = 1'b1; tick(); vidin_ack = 1'b0;
  endtask

  initial begin
    // reset values
    tick(); tick();
    chk("rst_vidin_req", 32'(vidin_req), 0);
    chk("rst_vidout_req", 32'(vidout_req), 0);
    chk("rst_out_empty", 32'(out_empty), 1);
    chk("rst_vidin_frame", 32'(vidin_frame), 0);
    chk("rst_vidout_frame", 32'(vidout_frame), 2);
    chk("rst_out_q", 32'(out_q), 0);
    chk("rst_vidin_d", 32'(vidin_d), 0);
    chk("rst_in_overflow", 32'(in_overflow), 0);
    chk("rst_out_underflow", 32'(out_underflow), 0);
    chk("rst_vidin_col", 32'(vidin_col), 0);
    reset = 1'b0;

    // single write burst
    in_frame_start = 1'b1; tick(); in_frame_start = 1'b0;
    chk("wb_frame", 32'(vidin_frame), 1);
    in_line_start = 1'b1; tick(); in_line_start = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    wait_in_req("wb_req");
    chk("wb_row", 32'(vidin_row), 0);
    chk("wb_col", 32'(vidin_col), 0);
    for (int i = 0; i < 8; i++) in_ack_word("wb_data", 32'h100 + i);
    chk("wb_req_low", 32'(vidin_req), 0);
    chk("wb_col_after", 32'(vidin_col), 8);
    chk("wb_empty_d", 32'(vidin_d), 0);

    // rest of the 64-word line, then no further request
    for (int b = 1; b < 8; b++) begin
      for (int i = 0; i < 8; i++) push(16'h0200 + 16'(b * 8 + i));
      wait_in_req("fl_req");
      chk("fl_col", 32'(vidin_col), 32'(b * 8));
      for (int i = 0; i < 8; i++) in_ack_word("fl_data", 32'h200 + b * 8 + i);
    end
    chk("fl_col_end", 32'(vidin_col), 64);
    for (int i = 0; i < 8; i++) push(16'h02F0 + 16'(i));
    repeat (4) tick();
    chk("fl_no_req", 32'(vidin_req), 0);

    // line start clears FIFO; a line start during a burst waits for the burst
    in_line_start = 1'b1; tick(); in_line_start = 1'b0;
    chk("ls_row1", 32'(vidin_row), 1);
    chk("ls_col0", 32'(vidin_col), 0);
    chk("ls_cleared", 32'(vidin_d), 0);
    for (int i = 0; i < 10; i++) push(16'h0300 + 16'(i));
    wait_in_req("ls_req");
    for (int i = 0; i < 3; i++) in_ack_word("ls_data", 32'h300 + i);
    in_line_start = 1'b1; tick(); in_line_start = 1'b0;
    chk("ls_pend_req", 32'(vidin_req), 1);
    chk("ls_pend_row", 32'(vidin_row), 1);
    for (int i = 3; i < 8; i++) in_ack_word("ls_data", 32'h300 + i);
    chk("ls_done_req", 32'(vidin_req), 0);
    chk("ls_done_col", 32'(vidin_col), 8);
    chk("ls_done_head", 32'(vidin_d), 32'h308);
    tick();
    chk("ls_apply_row", 32'(vidin_row), 2);
    chk("ls_apply_col", 32'(vidin_col), 0);
    chk("ls_apply_empty", 32'(vidin_d), 0);

    // overflow: 17 pushes, no acks
    for (int i = 0; i < 16; i++) push(16'h0400 + 16'(i));
    chk("ov_not_yet", 32'(in_overflow), 0);
    push(16'h04FF);
    chk("ov_set", 32'(in_overflow), 1);
    chk("ov_head", 32'(vidin_d), 32'h400);
    repeat (3) tick();
    chk("ov_sticky", 32'(in_overflow), 1);

    // reset in the middle of a burst, then a stray ack on an empty FIFO
    vidin_ack = 1'b1; tick(); vidin_ack = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mr_req", 32'(vidin_req), 0);
    chk("mr_ovf", 32'(in_overflow), 0);
    chk("mr_d", 32'(vidin_d), 0);
    chk("mr_frame", 32'(vidin_frame), 0);
    vidin_ack = 1'b1; tick(); vidin_ack = 1'b0;
    chk("stray_ack_ovf", 32'(in_overflow), 1);

    // triple buffer
    in_frame_start = 1'b1; tick(); in_frame_start = 1'b0;
    chk("tb_f1", 32'(vidin_frame), 1);
    in_frame_start = 1'b1; tick(); in_frame_start = 1'b0;
    chk("tb_f2", 32'(vidin_frame), 0);
    in_frame_start = 1'b1; tick(); in_frame_start = 1'b0;
    chk("tb_f3", 32'(vidin_frame), 1);
    chk("tb_distinct", 32'(vidin_frame != vidout_frame), 1);
    out_frame_start = 1'b1; tick(); out_frame_start = 1'b0;
    chk("tb_out_frame", 32'(vidout_frame), 0);
    in_frame_start = 1'b1; tick(); in_frame_start = 1'b0;
    chk("tb_f4", 32'(vidin_frame), 2);

    // read prefetch of row 5
    out_row = 11'd5; out_line_start = 1'b1; tick(); out_line_start = 1'b0;
    chk("rd_req_drop", 32'(vidout_req), 0);
    repeat (20) tick();
    chk("rd_flush_quiet", 32'(vidout_req), 0);
    for (int b = 0; b < 4; b++) begin
      wait_out_req("rd_req");
      chk("rd_row", 32'(vidout_row), 5);
      chk("rd_col", 32'(vidout_col), 32'(b * 8));
      for (int i = 0; i < 8; i++) begin
        vidout_ack = 1'b1; vidout_q = 16'h00A0 + 16'(b * 8 + i); tick();
      end
      vidout_ack = 1'b0;
      chk("rd_req_low", 32'(vidout_req), 0);
      if (b == 0) begin
        chk("rd_head", 32'(out_q), 32'hA0);
        chk("rd_nonempty", 32'(out_empty), 0);
      end
    end
    repeat (5) tick();
    chk("rd_withheld", 32'(vidout_req), 0);
    chk("rd_col32", 32'(vidout_col), 32);
    for (int i = 0; i < 8; i++) begin
      chk("rd_pop", 32'(out_q), 32'hA0 + i);
      out_rd = 1'b1; tick(); out_rd = 1'b0;
    end
    wait_out_req("rd_resume");
    for (int i = 0; i < 8; i++) begin
      chk("rd_pop_mid", 32'(out_q), 32'hA8 + i);
      out_rd = 1'b1; vidout_ack = 1'b1; vidout_q = 16'h00C0 + 16'(i); tick();
    end
    out_rd = 1'b0; vidout_ack = 1'b0;
    chk("rd_mid_head", 32'(out_q), 32'hB0);
    chk("rd_col40", 32'(vidout_col), 40);

    // flush while acks arrive, second line start restarts the quiet window
    wait_out_req("fx_req");
    for (int i = 0; i < 3; i++) begin
      vidout_ack = 1'b1; vidout_q = 16'h00C8 + 16'(i); tick();
    end
    out_row = 11'd9; out_line_start = 1'b1; vidout_q = 16'h00EE; tick();
    out_line_start = 1'b0;
    chk("fx_req_drop", 32'(vidout_req), 0);
    repeat (4) tick();
    vidout_ack = 1'b0;
    repeat (5) tick();
    out_row = 11'd7; out_line_start = 1'b1; tick(); out_line_start = 1'b0;
    repeat (23) tick();
    chk("fx_window_req", 32'(vidout_req), 0);
    chk("fx_not_cleared", 32'(out_empty), 0);
    chk("fx_old_row", 32'(vidout_row), 5);
    chk("fx_old_head", 32'(out_q), 32'hB0);
    tick();
    chk("fx_cleared", 32'(out_empty), 1);
    chk("fx_q0", 32'(out_q), 0);
    chk("fx_row", 32'(vidout_row), 7);
    chk("fx_col", 32'(vidout_col), 0);
    tick();
    chk("fx_new_req", 32'(vidout_req), 1);
    chk("uf_clear", 32'(out_underflow), 0);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    chk("uf_set", 32'(out_underflow), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
